// File: rtl/fp_posit_serial_mul.sv
// Bit-serial multiplier: an FP activation times a posit weight that arrives MSB first.
// Build option FP_POSIT_SPECIAL_EN also flags activation zero/NaR from its exponent field.
module fp_posit_serial_mul #(
    parameter int ACT_WIDTH = 16,
    parameter int EXP_WIDTH = 5,
    parameter int MAN_WIDTH = 10,
    parameter int MAX_PREC  = 8,
    parameter int ES        = 1,
    localparam int FMAX = MAX_PREC - 3 - ES,
    localparam int PW   = MAN_WIDTH + 2 + FMAX,
    localparam int EW   = EXP_WIDTH + 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ACT_WIDTH-1:0] act,
    input  logic                 w,
    input  logic                 valid,
    input  logic                 set,
    input  logic [3:0]           precision,
    output logic                 busy,
    output logic                 out_valid,
    output logic                 sign_out,
    output logic [EW-1:0]        exp_out,
    output logic [PW-1:0]        mant_out,
    output logic                 zero_out,
    output logic                 NaR_out
);
    localparam int EB = (ES > 0) ? ES : 1;

    typedef enum logic [1:0] {IDLE, REGIME, EXP, FRAC} state_t;

    state_t               state, nx_state;
    logic [4:0]           cnt, nx_cnt, n_lat, prec_c;
    logic [4:0]           run, nx_run, f_cnt, nx_f;
    logic [1:0]           e_cnt, nx_ecnt;
    logic [EB-1:0]        e_val, nx_e;
    logic                 a_sign, nx_a_sign, p_sign, nx_p_sign;
    logic                 r0, nx_r0, nz, nx_nz, last;
    logic [EXP_WIDTH-1:0] a_exp, nx_a_exp;
    logic [MAN_WIDTH-1:0] a_man, nx_a_man;
    logic [PW-1:0]        acc, nx_acc;

    logic [EW-1:0]        k_v, x_v;
    logic [PW-1:0]        m_v;
    logic                 a_zero, a_nar, res_zero, res_nar;

    assign busy = (state != IDLE);

    always_comb begin
        prec_c = {1'b0, precision};
        if ({1'b0, precision} < 5'd3)
            prec_c = 5'd3;
        else if ({1'b0, precision} > 5'(MAX_PREC))
            prec_c = 5'(MAX_PREC);
    end

    // Next-state of the word decoder, including the bit being presented this cycle.
    always_comb begin
        nx_state  = state;
        nx_cnt    = cnt;
        nx_run    = run;
        nx_f      = f_cnt;
        nx_ecnt   = e_cnt;
        nx_e      = e_val;
        nx_a_sign = a_sign;
        nx_a_exp  = a_exp;
        nx_a_man  = a_man;
        nx_p_sign = p_sign;
        nx_r0     = r0;
        nx_nz     = nz;
        nx_acc    = acc;
        last      = 1'b0;
        if (!valid) begin
            nx_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    nx_a_sign = act[ACT_WIDTH-1];
                    nx_a_exp  = act[MAN_WIDTH +: EXP_WIDTH];
                    nx_a_man  = act[MAN_WIDTH-1:0];
                    nx_acc    = PW'({1'b1, act[MAN_WIDTH-1:0]});
                    nx_p_sign = w;
                    nx_nz     = 1'b0;
                    nx_run    = 5'd0;
                    nx_r0     = 1'b0;
                    nx_e      = '0;
                    nx_ecnt   = 2'd0;
                    nx_f      = 5'd0;
                    nx_cnt    = 5'd1;
                    nx_state  = REGIME;
                end
                REGIME: begin
                    nx_nz = nz | w;
                    if (run == 5'd0) begin
                        nx_r0  = w;
                        nx_run = 5'd1;
                    end else if (w == r0) begin
                        nx_run = run + 5'd1;
                    end else begin
                        nx_state = (ES == 0) ? FRAC : EXP;
                    end
                end
                EXP: begin
                    nx_nz   = nz | w;
                    nx_e    = EB'((e_val << 1) | EB'(w));
                    nx_ecnt = e_cnt + 2'd1;
                    if (e_cnt + 2'd1 == 2'(ES))
                        nx_state = FRAC;
                end
                FRAC: begin
                    nx_nz  = nz | w;
                    nx_acc = (acc << 1) + (w ? PW'({1'b1, a_man}) : '0);
                    nx_f   = f_cnt + 5'd1;
                end
                default: nx_state = IDLE;
            endcase
            if (state != IDLE) begin
                nx_cnt = cnt + 5'd1;
                if (cnt == n_lat - 5'd1) begin
                    last     = 1'b1;
                    nx_state = IDLE;
                end
            end
        end
    end

    // Result assembly; exponent math is modulo 2^EW, i.e. two's complement.
    always_comb begin
        k_v = nx_r0 ? (EW'(nx_run) - EW'(1)) : (EW'(0) - EW'(nx_run));
        x_v = EW'(nx_a_exp) + (k_v << ES) + (EW'(nx_e) << (2'(ES) - nx_ecnt));
        m_v = nx_acc << (5'(FMAX) - nx_f);
`ifdef FP_POSIT_SPECIAL_EN
        a_zero = (nx_a_exp == '0);
        a_nar  = &nx_a_exp;
`else
        a_zero = 1'b0;
        a_nar  = 1'b0;
`endif
        res_nar  = (!nx_nz && nx_p_sign) || a_nar;
        res_zero = ((!nx_nz && !nx_p_sign) || a_zero) && !res_nar;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            n_lat     <= 5'(MAX_PREC);
            run       <= 5'd0;
            f_cnt     <= 5'd0;
            e_cnt     <= 2'd0;
            e_val     <= '0;
            a_sign    <= 1'b0;
            a_exp     <= '0;
            a_man     <= '0;
            p_sign    <= 1'b0;
            r0        <= 1'b0;
            nz        <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            sign_out  <= 1'b0;
            exp_out   <= '0;
            mant_out  <= '0;
            zero_out  <= 1'b0;
            NaR_out   <= 1'b0;
        end else begin
            state     <= nx_state;
            cnt       <= nx_cnt;
            run       <= nx_run;
            f_cnt     <= nx_f;
            e_cnt     <= nx_ecnt;
            e_val     <= nx_e;
            a_sign    <= nx_a_sign;
            a_exp     <= nx_a_exp;
            a_man     <= nx_a_man;
            p_sign    <= nx_p_sign;
            r0        <= nx_r0;
            nz        <= nx_nz;
            acc       <= nx_acc;
            out_valid <= last;
            if (set && state == IDLE)
                n_lat <= prec_c;
            if (last) begin
                sign_out <= nx_a_sign ^ nx_p_sign;
                zero_out <= res_zero;
                NaR_out  <= res_nar;
                exp_out  <= (res_zero || res_nar) ? '0 : x_v;
                mant_out <= (res_zero || res_nar) ? '0 : m_v;
            end
        end
    end
endmodule
